// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bus bundle between the two result producers, the CDB
// arbiter and the CDB snoopers.
//   rdy / rollback           : global pause and mispredict flush
//   alu_valid/rob_id/data    : ALU result push;  alu_full back to the RS
//   lsb_valid/rob_id/data    : LSB result push;  lsb_full back to the LSB
//   cdb_valid/rob_id/data/src: registered broadcast (src 0 = ALU, 1 = LSB)
//   overflow                 : sticky dropped-push indicator
// master = producer/consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
);
  logic                rdy;
  logic                rollback;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_full;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [DATA_W-1:0]   lsb_data;
  logic                lsb_full;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_data;
  logic                cdb_src;
  logic                overflow;

  modport master (
    output rdy, rollback,
    output alu_valid, alu_rob_id, alu_data,
    output lsb_valid, lsb_rob_id, lsb_data,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_id, cdb_data, cdb_src, overflow
  );

  modport slave (
    input  rdy, rollback,
    input  alu_valid, alu_rob_id, alu_data,
    input  lsb_valid, lsb_rob_id, lsb_data,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_id, cdb_data, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU and the LSB.
// Each source pushes into its own small FIFO; a round-robin arbiter pops
// at most one head per cycle onto the registered CDB.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (also clears the sticky overflow)
//   bus  - cdb_arbiter_if.slave: rdy, rollback, per-source pushes, full
//          flags, registered CDB broadcast, sticky overflow.
// Source index 0 is the ALU, index 1 is the LSB throughout.
module cdb_arbiter #(
  parameter int ROB_ID_W   = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // Per-source views of the push ports so both FIFOs share one code path.
  logic [1:0]          in_valid;
  logic [ROB_ID_W-1:0] in_id   [2];
  logic [DATA_W-1:0]   in_data [2];

  assign in_valid[0] = bus.alu_valid;
  assign in_valid[1] = bus.lsb_valid;
  assign in_id[0]    = bus.alu_rob_id;
  assign in_id[1]    = bus.lsb_rob_id;
  assign in_data[0]  = bus.alu_data;
  assign in_data[1]  = bus.lsb_data;

  // FIFO storage and pointers.
  logic [ROB_ID_W-1:0] id_mem_q   [2][FIFO_DEPTH];
  logic [ROB_ID_W-1:0] id_mem_d   [2][FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem_q [2][FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem_d [2][FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q [2], rd_ptr_d [2];
  logic [PTR_W-1:0]    wr_ptr_q [2], wr_ptr_d [2];
  logic [CNT_W-1:0]    cnt_q    [2], cnt_d    [2];

  // Broadcast and arbitration state.
  logic                cdb_valid_q,  cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_data_q,   cdb_data_d;
  logic                cdb_src_q,    cdb_src_d;
  logic                last_grant_q, last_grant_d;
  logic                overflow_q,   overflow_d;

  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] push_req;   // acceptable push, before rdy/rollback gating
  logic [1:0] drop_full;  // non-zero push that hits a full FIFO
  logic [1:0] pop_sel;
  logic       grant_any;
  logic       grant_src;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign full[gi]      = (cnt_q[gi] == DEPTH_CNT);
      assign nonempty[gi]  = (cnt_q[gi] != '0);
      // Full is sampled before this cycle's pop, so a pop never makes
      // room for a same-cycle push.
      assign push_req[gi]  = in_valid[gi] && (in_id[gi] != '0) && !full[gi];
      assign drop_full[gi] = in_valid[gi] && (in_id[gi] != '0) && full[gi];
      assign pop_sel[gi]   = grant_any && (grant_src == 1'(gi));
    end
  endgenerate

  // Round-robin: on a tie the source that did not win last time goes.
  always_comb begin
    grant_any = |nonempty;
    grant_src = 1'b0;
    if (&nonempty) begin
      grant_src = ~last_grant_q;
    end else if (nonempty[1]) begin
      grant_src = 1'b1;
    end
  end

  always_comb begin
    id_mem_d     = id_mem_q;
    data_mem_d   = data_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    overflow_d   = overflow_q;

    if (bus.rollback) begin
      // Flush everything in flight; overflow is deliberately left alone.
      for (int i = 0; i < 2; i++) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
      cdb_valid_d  = 1'b0;
      cdb_rob_id_d = '0;
      cdb_data_d   = '0;
      cdb_src_d    = 1'b0;
      last_grant_d = 1'b1;
    end else if (bus.rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (push_req[i]) begin
          id_mem_d[i][wr_ptr_q[i]]   = in_id[i];
          data_mem_d[i][wr_ptr_q[i]] = in_data[i];
          wr_ptr_d[i]                = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop_sel[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        end
        case ({push_req[i], pop_sel[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end

      if (|drop_full) begin
        overflow_d = 1'b1;
      end

      if (grant_any) begin
        cdb_valid_d  = 1'b1;
        cdb_rob_id_d = id_mem_q[grant_src][rd_ptr_q[grant_src]];
        cdb_data_d   = data_mem_q[grant_src][rd_ptr_q[grant_src]];
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
      end else begin
        // Id/data keep their last values; only valid drops.
        cdb_valid_d = 1'b0;
      end
    end
  end

  // Storage carries no reset: empty FIFOs never expose stale entries.
  always_ff @(posedge clk) begin
    id_mem_q   <= id_mem_d;
    data_mem_q <= data_mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.alu_full   = full[0];
  assign bus.lsb_full   = full[1];
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_data   = cdb_data_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.overflow   = overflow_q;

endmodule
